// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scanner
//  Purpose  : Autonomous 4-digit multiplexed common-anode 7-segment driver.
//             A refresh counter steps the active-low digit enables. Each slot
//             shows one hex nibble of a frame-synchronous copy of a 16-bit value.
//             Every slot ends in a guard interval with all digits off.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  transistor,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);

    localparam int                c_CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(REFRESH_DIV - 1);
    // Held as 32 bits because REFRESH_DIV itself (BLANK_CYCLES = 0) may not fit c_CNT_W.
    localparam logic [31:0]        c_ON_END = 32'(REFRESH_DIV - BLANK_CYCLES);

    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_digit;
    logic [15:0]        r_shown;
    logic [15:0]        r_pending;
    logic               r_pend;
    logic               r_frame_tick;

    logic [31:0]        w_cnt32;
    logic               w_slot_end;
    logic               w_boundary;
    logic               w_on;
    logic [3:0]         w_blank;
    logic [3:0]         w_nib;

    // Active-low a..g pattern for one hex nibble.
    function automatic logic [6:0] f_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign w_cnt32    = {{(32-c_CNT_W){1'b0}}, r_cnt};
    assign w_slot_end = (r_cnt == c_LAST);
    assign w_boundary = w_slot_end && (r_digit == 2'd3);
    assign w_nib      = r_shown[{r_digit, 2'b00} +: 4];

    // Digit k (k >= 1) is a leading zero when it and every digit above it are zero.
    assign w_blank[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_lz
            assign w_blank[gi] = blank_lz && (r_shown[15:4*gi] == '0);
        end
    endgenerate

    // A slot is lit only in its ON phase and when not suppressed as a leading zero.
    assign w_on = (w_cnt32 < c_ON_END) && !w_blank[r_digit];

    // Slot counter and digit rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_digit <= 2'd0;
        end else if (w_slot_end) begin
            r_cnt   <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_cnt   <= r_cnt + c_CNT_W'(1);
        end
    end

    // Value capture: loads queue in pending, shown only updates at the frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shown   <= 16'h0000;
            r_pending <= 16'h0000;
            r_pend    <= 1'b0;
        end else begin
            if (load) begin
                r_pending <= value;
            end
            if (w_boundary) begin
                if (load) begin
                    r_shown <= value;
                end else if (r_pend) begin
                    r_shown <= r_pending;
                end
                r_pend <= 1'b0;
            end else if (load) begin
                r_pend <= 1'b1;
            end
        end
    end

    // Frame tick is high during the first cycle of the digit-0 slot after a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_boundary;
        end
    end

    // Pin drive: lit slot shows its nibble, otherwise everything is dark.
    always_comb begin
        transistor = 4'b1111;
        seg        = 7'b1111111;
        dp         = 1'b1;
        if (w_on) begin
            transistor = ~(4'b0001 << r_digit);
            seg        = f_decode(w_nib);
            dp         = ~dp_en[r_digit];
        end
    end

    assign digit_idx  = r_digit;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_scanner
//  Purpose  : Directed self-checking bench for seven_seg_scanner
//             (REFRESH_DIV=8, BLANK_CYCLES=2) with an expected-output queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_en;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  transistor;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    seven_seg_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .dp_en      (dp_en),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .transistor (transistor),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [3:0] tr;
        logic [6:0] sg;
        logic       dpv;
        logic [1:0] idx;
        logic       tick;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          k      = 0;
    logic [15:0] s_tbl [8];
    logic [6:0]  dec   [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Expected pins at cycle kk after reset release; shown value by frame from s_tbl.
    function automatic exp_t model(int kk);
        exp_t        e;
        int          c;
        int          d;
        logic [15:0] s;
        logic [3:0]  nib;
        logic        blank;
        logic        on;
        c     = kk % 8;
        d     = (kk / 8) % 4;
        s     = s_tbl[(kk / 32) % 8];
        nib   = s[4*d +: 4];
        blank = blank_lz && (d != 0) && ((s >> (4*d)) == 16'h0000);
        on    = (c < 6) && !blank;
        e.k    = kk;
        e.tr   = on ? ~(4'b0001 << d) : 4'b1111;
        e.sg   = on ? dec[nib] : 7'b1111111;
        e.dpv  = on ? ~dp_en[d] : 1'b1;
        e.idx  = 2'(d);
        e.tick = (kk != 0) && (kk % 32 == 0);
        return e;
    endfunction

    task automatic cmp();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (transistor === e.tr) else begin
            errors++;
            $error("FAIL transistor k=%0d observed=%b expected=%b", e.k, transistor, e.tr);
        end
        checks++;
        assert (seg === e.sg) else begin
            errors++;
            $error("FAIL seg k=%0d observed=%b expected=%b", e.k, seg, e.sg);
        end
        checks++;
        assert (dp === e.dpv) else begin
            errors++;
            $error("FAIL dp k=%0d observed=%b expected=%b", e.k, dp, e.dpv);
        end
        checks++;
        assert (digit_idx === e.idx) else begin
            errors++;
            $error("FAIL digit_idx k=%0d observed=%0d expected=%0d", e.k, digit_idx, e.idx);
        end
        checks++;
        assert (frame_tick === e.tick) else begin
            errors++;
            $error("FAIL frame_tick k=%0d observed=%b expected=%b", e.k, frame_tick, e.tick);
        end
    endtask

    // Advance one clock: expectation queued with the stimulus, checked at the next negedge.
    task automatic step();
        k++;
        sb.push_back(model(k));
        @(negedge clk);
        cmp();
    endtask

    task automatic run_to(int n);
        while (k < n) step();
    endtask

    task automatic load_value(logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        s_tbl    = '{16'h0000, 16'h0000, 16'hA5C3, 16'h9ABC,
                     16'h1234, 16'h0040, 16'h0000, 16'h7E21};
        rst_n    = 1'b0;
        value    = 16'h0000;
        load     = 1'b0;
        dp_en    = 4'b0000;
        blank_lz = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        sb.push_back(model(0));
        cmp();
        rst_n = 1'b1;
        #1;
        k = 0;
        sb.push_back(model(0));
        cmp();

        // Frames 0-1 show 0000; a load mid-frame-1 waits for the wrap.
        run_to(35);
        load_value(16'hA5C3);
        // Frame 2 shows A5C3; two loads in it, last wins at the next wrap.
        run_to(70);
        load_value(16'h5678);
        run_to(80);
        load_value(16'h9ABC);
        run_to(95);
        dp_en = 4'b1010;
        // Frame 3 shows 9ABC; a load on the boundary cycle bypasses to frame 4.
        run_to(127);
        blank_lz = 1'b1;
        load_value(16'h1234);
        run_to(130);
        load_value(16'h0040);
        run_to(159);
        dp_en = 4'b0001;
        // Frame 5: 0040 with leading-zero blanking.
        run_to(165);
        load_value(16'h0000);
        run_to(191);
        dp_en = 4'b1101;
        // Frame 6: 0000 blanked down to digit 0; dp_en must not unblank.
        run_to(200);
        load_value(16'h7E21);
        run_to(223);
        blank_lz = 1'b0;
        dp_en    = 4'b0000;
        // Frame 7: 7E21, then async reset in the middle of digit 2.
        run_to(243);
        rst_n = 1'b0;
        #1;
        s_tbl = '{default: 16'h0000};
        sb.push_back(model(0));
        cmp();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        k = 0;
        sb.push_back(model(0));
        cmp();
        // After reset shown is 0 and nothing is pending across the first wrap.
        run_to(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
